regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of register data.
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port Req, input, 4 bits: Req[i] high = requester i wants one register write.
REQ-005 SHALL have port ReqAdr, input, 20 bits: requester i address in bits [5i+4:5i].
REQ-006 SHALL have port ReqData, input, 4*DATA_W bits: requester i data in slice i.
REQ-007 SHALL have port Gnt, output, 4 bits: one-hot grant, registered.
REQ-008 SHALL have port WrEn, output, 1 bit: register file write enable, registered.
REQ-009 SHALL have port WrAdr, output, 5 bits: write address, drives the 5-to-32 decoder, registered.
REQ-010 SHALL have port WrData, output, DATA_W bits: write data, registered.
REQ-011 SHALL have port Ready, output, 1 bit: high once register clear sweep is complete.

Function
REQ-012 SHALL implement two states, INIT and ARB, plus a 5-bit clear counter ClrCnt and a 2-bit round-robin pointer Ptr.
REQ-013 In INIT, each edge SHALL drive WrEn=1, WrAdr=ClrCnt, WrData=0, Gnt=0, then increment ClrCnt.
REQ-014 INIT SHALL write addresses 0..31 on 32 consecutive edges after reset release (E1..E32); at E33 SHALL drive WrEn=0, Ready=1 and enter ARB.
REQ-015 Req SHALL be ignored in INIT; requests held high SHALL be serviced after Ready rises.
REQ-016 In ARB, each edge SHALL select the first eligible requester scanning Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4).
REQ-017 Eligible = Req[i]=1 and Gnt[i]=0 in the current cycle (requester just granted is masked for one edge).
REQ-018 On a selection g, the same edge SHALL register Gnt=one-hot(g), WrEn=1, WrAdr=ReqAdr slice g, WrData=ReqData slice g, and Ptr=g+1 mod 4.
REQ-019 With no eligible requester, the edge SHALL register Gnt=0, WrEn=0; WrAdr, WrData and Ptr SHALL hold.
REQ-020 Latency SHALL be one cycle: Req sampled at edge k gives Gnt/WrEn valid from edge k until edge k+1.
REQ-021 Gnt SHALL be a one-cycle pulse per write; requester SHALL drop Req or present the next write in the cycle after Gnt.
REQ-022 A single continuously requesting requester SHALL receive a grant every second edge; two or more SHALL yield a write every edge.
REQ-023 Gnt SHALL never have more than one bit set; WrEn SHALL equal OR of Gnt in ARB.
REQ-024 Ready SHALL stay 1 in ARB until next reset.

Reset
REQ-025 Rst=1 at an edge SHALL set state=INIT, ClrCnt=0, Ptr=0, Gnt=0, WrEn=0, WrAdr=0, WrData=0, Ready=0.
REQ-026 Rst asserted mid-sweep or mid-grant SHALL abort immediately; pending requests SHALL be dropped and the sweep SHALL restart from address 0.
REQ-027 Rst SHALL take priority over all other inputs at the same edge.

Verification
REQ-028 Reset release, Req=0 -> WrEn=1 at E1..E32 with WrAdr 0,1,..,31, WrData=0; E33 WrEn=0, Ready=1.
REQ-029 Req=4'b1111 held from reset, distinct addresses/data -> no Gnt before E34; from E34 Gnt=0001,0010,0100,1000,0001 on consecutive edges, WrAdr/WrData match granted slice.
REQ-030 In ARB, only Req[2]=1 held, ReqAdr slice 2=5'd7, data 32'hDEADBEEF -> Gnt=0100, WrAdr=7, WrData=32'hDEADBEEF on alternate edges, Gnt=0 between.
REQ-031 Ptr=1 after grant to 0, then Req=4'b1001 -> grant 3 before 0 (Gnt=1000 then 0001).
REQ-032 Rst pulsed at sweep address 15 -> next edges restart WrAdr=0, Ready=0, 32 full writes before Ready=1.
REQ-033 Assertions every cycle: Gnt one-hot or zero; no Gnt while Ready=0 outside INIT clear writes.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ==================================================================
// regfile_wr_arbiter_if: requester and register-file write bundle.
// Rev 1.0
// ==================================================================
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [3:0]          Req;
  logic [19:0]         ReqAdr;
  logic [4*DATA_W-1:0] ReqData;
  logic [3:0]          Gnt;
  logic                WrEn;
  logic [4:0]          WrAdr;
  logic [DATA_W-1:0]   WrData;
  logic                Ready;

  modport master (
    output Req, ReqAdr, ReqData,
    input  Gnt, WrEn, WrAdr, WrData, Ready
  );

  modport slave (
    input  Req, ReqAdr, ReqData,
    output Gnt, WrEn, WrAdr, WrData, Ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ==================================================================
// regfile_wr_arbiter: clears all 32 registers after reset, then
// round-robin arbitrates four write requesters. Rev 1.0
// ==================================================================
module regfile_wr_arbiter #(
  parameter int DATA_W = 32
) (
  input wire Clk,
  input wire Rst,
  regfile_wr_arbiter_if.slave bus
);
  typedef enum logic [0:0] {INIT = 1'b0, ARB = 1'b1} state_t;

  state_t            r_state;
  logic [4:0]        r_clr_cnt;
  logic              r_clr_done;
  logic [1:0]        r_ptr;

  logic [4:0]        w_adr  [4];
  logic [DATA_W-1:0] w_data [4];
  logic              w_sel_vld;
  logic [1:0]        w_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    assign w_adr[gi]  = bus.ReqAdr[5*gi +: 5];
    assign w_data[gi] = bus.ReqData[DATA_W*gi +: DATA_W];
  end

  // A requester granted on the previous edge is masked so the bus alternates.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = r_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!w_sel_vld && bus.Req[r_ptr + 2'(k)] && !bus.Gnt[r_ptr + 2'(k)]) begin
        w_sel_vld = 1'b1;
        w_sel     = r_ptr + 2'(k);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= INIT;
      r_clr_cnt  <= 5'd0;
      r_clr_done <= 1'b0;
      r_ptr      <= 2'd0;
      bus.Gnt    <= 4'd0;
      bus.WrEn   <= 1'b0;
      bus.WrAdr  <= 5'd0;
      bus.WrData <= '0;
      bus.Ready  <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          bus.Gnt    <= 4'd0;
          bus.WrData <= '0;
          // One idle edge after address 31 before Ready rises.
          if (r_clr_done) begin
            bus.WrEn  <= 1'b0;
            bus.Ready <= 1'b1;
            r_state   <= ARB;
          end else begin
            bus.WrEn  <= 1'b1;
            bus.WrAdr <= r_clr_cnt;
            r_clr_cnt <= r_clr_cnt + 5'd1;
            if (r_clr_cnt == 5'd31) begin
              r_clr_done <= 1'b1;
            end
          end
        end
        ARB: begin
          if (w_sel_vld) begin
            bus.Gnt    <= 4'd1 << w_sel;
            bus.WrEn   <= 1'b1;
            bus.WrAdr  <= w_adr[w_sel];
            bus.WrData <= w_data[w_sel];
            r_ptr      <= w_sel + 2'd1;
          end else begin
            bus.Gnt  <= 4'd0;
            bus.WrEn <= 1'b0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end
endmodule
`default_nettype wire
